rng_ctrl: RTL

RNG_CTRL -- requirements
Module: rng_ctrl

---
 rtl/rng_pkg.sv | 19 +
 rtl/rng_fifo.sv | 59 +++++
 rtl/rng_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
// rng_pkg: shared types and default constants for the RNG controller.
//   rng_state_e      - controller FSM states
//   DEF_WARMUP_CYC   - default warm-up length in cycles
//   DEF_REP_LIMIT    - default repetition-test run length that trips a fault
//   DEF_DEPTH        - default output FIFO depth (power of two, >= 2)
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    SAMPLE = 2'd2,
    FAULT  = 2'd3
  } rng_state_e;

  localparam int DEF_WARMUP_CYC = 16;
  localparam int DEF_REP_LIMIT  = 4;
  localparam int DEF_DEPTH      = 4;

endpackage

// File: rtl/rng_fifo.sv
// rng_fifo: synchronous DEPTH x 8 FIFO with flush.
//   clk, rst_n - clock, synchronous active-low reset
//   flush      - empties the FIFO (wins over push/pop)
//   push/wdata - write request; ignored when full
//   pop        - read request; ignored when empty
//   rdata      - head byte, 0 when empty
//   count      - occupancy, 0..DEPTH
//   empty      - count == 0
module rng_fifo import rng_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic [AW:0]   count,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= wdata;
  end

  // Storage is not reset; hide stale contents behind the empty flag.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rng_ctrl.sv
// rng_ctrl: ring-oscillator RNG controller. Warms up the generator, samples
// bytes into an output FIFO, and runs a repetition health test.
//   clk, rst_n           - clock, synchronous active-low reset
//   start                - level request to keep the FIFO filled
//   rng_en               - generator enable (WARMUP/SAMPLE)
//   rng_data             - raw generator byte
//   out_data/out_valid   - FIFO head and valid (suppressed while faulted)
//   out_ready            - consumer accept
//   fault / fault_clr    - sticky health-test failure and its clear
//   busy                 - FSM in WARMUP or SAMPLE
module rng_ctrl import rng_pkg::*; #(
  parameter int WARMUP_CYC = DEF_WARMUP_CYC,
  parameter int REP_LIMIT  = DEF_REP_LIMIT,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       rng_en,
  input  logic [7:0] rng_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       fault,
  input  logic       fault_clr,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAST_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [WW-1:0] WARM_END = WW'(WARMUP_CYC - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);

  rng_state_e    state, nxt_state;
  logic [WW-1:0] warm_cnt, warm_nxt;
  logic [RW-1:0] rep_cnt, rep_nxt, rep_try;
  logic [7:0]    prev_byte, prev_nxt;
  logic [AW:0]   count;
  logic          empty, push, pop, flush;

  rng_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (rng_data),
    .pop   (pop),
    .rdata (out_data),
    .count (count),
    .empty (empty)
  );

  assign rng_en    = (state == WARMUP) || (state == SAMPLE);
  assign busy      = rng_en;
  assign fault     = (state == FAULT);
  assign out_valid = !empty && (state != FAULT);
  assign pop       = out_valid && out_ready;

  // prev_byte and rep_cnt both clear to 0 on warm-up entry, so a first
  // sample of 0x00 "matches" and counts 0+1 = 1, same as a fresh load of 1.
  assign rep_try = (rng_data == prev_byte) ? rep_cnt + 1'b1 : RW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      warm_cnt  <= '0;
      rep_cnt   <= '0;
      prev_byte <= '0;
    end else begin
      state     <= nxt_state;
      warm_cnt  <= warm_nxt;
      rep_cnt   <= rep_nxt;
      prev_byte <= prev_nxt;
    end
  end

  always_comb begin
    nxt_state = state;
    warm_nxt  = warm_cnt;
    rep_nxt   = rep_cnt;
    prev_nxt  = prev_byte;
    push      = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (start && (count < FULL_CNT)) begin
          nxt_state = WARMUP;
          warm_nxt  = '0;
          rep_nxt   = '0;
          prev_nxt  = '0;
        end
      end
      WARMUP: begin
        if (!start)                    nxt_state = IDLE;
        else if (warm_cnt == WARM_END) nxt_state = SAMPLE;
        else                           warm_nxt  = warm_cnt + 1'b1;
      end
      SAMPLE: begin
        prev_nxt = rng_data;
        rep_nxt  = rep_try;
        if (rep_try >= REP_MAX) begin
          // Offending byte is dropped and everything already queued is suspect.
          nxt_state = FAULT;
          flush     = 1'b1;
        end else begin
          push = (count < FULL_CNT);
          // Full after this push unless a pop frees the slot in the same cycle.
          if (!start || ((count == LAST_CNT) && !pop)) nxt_state = IDLE;
        end
      end
      FAULT: begin
        if (fault_clr) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule
